// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the branch target buffer entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // Tag field sized for the smallest legal table (2 entries -> PC[31:3]).
   // Larger tables store their shorter tag zero-extended into this field.
   localparam int BTB_TAG_W = 29;

   // 2-bit direction counter states
   localparam logic [1:0] SNT = 2'd0;   // strongly not-taken
   localparam logic [1:0] WNT = 2'd1;   // weakly not-taken
   localparam logic [1:0] WT  = 2'd2;   // weakly taken
   localparam logic [1:0] ST  = 2'd3;   // strongly taken

   typedef struct packed {
      logic                 valid;
      logic [BTB_TAG_W-1:0] tag;
      word_t                target;
      logic [1:0]           ctr;
   } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating direction counter next-state function.
// Latency: combinational.
// Backpressure: none.
module sat_counter2
   import cpu_types_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);

   // Step towards ST on taken, towards SNT on not-taken, clamping at the ends
   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != SNT) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC generator: direct-mapped BTB with 2-bit counters, mispredict redirect, perf counters.
// Latency: prediction combinational from fetch_PC; training visible to lookups the next cycle.
// Backpressure: none; a stalled PC simply ignores next_PC and lookups have no side effects.
module branch_predictor
   import cpu_types_pkg::*;
#(
   parameter int BTB_ENTRIES = 16
)
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] fetch_PC,
   input  logic [31:0] PC4,
   input  logic        mispredict,
   input  logic [31:0] correct_PC,
   input  logic        upd_valid,
   input  logic [31:0] upd_PC,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   output logic [31:0] next_PC,
   output logic        pred_taken,
   output logic [31:0] br_count,
   output logic [31:0] mp_count
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   btb_entry_t btb [BTB_ENTRIES];

   logic [IDX_W-1:0]     fetch_idx;
   logic [BTB_TAG_W-1:0] fetch_tag;
   btb_entry_t           fetch_entry;
   logic                 fetch_hit;

   logic [IDX_W-1:0]     upd_idx;
   logic [BTB_TAG_W-1:0] upd_tag;
   btb_entry_t           upd_entry;
   logic                 upd_hit;
   logic [1:0]           upd_ctr_next;

   logic                 wr_en;
   btb_entry_t           wr_entry;

   // Word-alignment bits never take part in indexing or tagging
   logic unused_pc_bits;
   assign unused_pc_bits = ^{fetch_PC[1:0], upd_PC[1:0]};

   // Lookup: split fetch_PC into index/tag and read the entry it maps to
   always_comb begin
      fetch_idx                = fetch_PC[IDX_W+1:2];
      fetch_tag                = '0;
      fetch_tag[TAG_W-1:0]     = fetch_PC[31:IDX_W+2];
      fetch_entry              = btb[fetch_idx];
      fetch_hit                = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
   end

   // Prediction and next-PC select; reset forces a plain sequential fetch
   always_comb begin
      pred_taken = 1'b0;
      next_PC    = PC4;
      if (!RST) begin
         pred_taken = fetch_hit && fetch_entry.ctr[1];
         if (mispredict)      next_PC = correct_PC;
         else if (pred_taken) next_PC = fetch_entry.target;
      end
   end

   // Training side: read the entry addressed by the resolved branch
   always_comb begin
      upd_idx              = upd_PC[IDX_W+1:2];
      upd_tag              = '0;
      upd_tag[TAG_W-1:0]   = upd_PC[31:IDX_W+2];
      upd_entry            = btb[upd_idx];
      upd_hit              = upd_entry.valid && (upd_entry.tag == upd_tag);
   end

   sat_counter2 u_ctr (
      .ctr      (upd_entry.ctr),
      .taken    (upd_taken),
      .ctr_next (upd_ctr_next)
   );

   // Build the single write: counter step on hit, allocate on taken miss, nothing on not-taken miss
   always_comb begin
      wr_en    = 1'b0;
      wr_entry = upd_entry;
      if (upd_valid) begin
         if (upd_hit) begin
            wr_en        = 1'b1;
            wr_entry.ctr = upd_ctr_next;
            if (upd_taken) wr_entry.target = upd_target;
         end else if (upd_taken) begin
            wr_en           = 1'b1;
            wr_entry.valid  = 1'b1;
            wr_entry.tag    = upd_tag;
            wr_entry.target = upd_target;
            wr_entry.ctr    = WT;
         end
      end
   end

   // Table state: reset invalidates everything and parks counters at weakly not-taken
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb[i].valid <= 1'b0;
            btb[i].ctr   <= WNT;
         end
      end else if (wr_en) begin
         btb[upd_idx] <= wr_entry;
      end
   end

   // Performance counters, saturating; a redirect without a resolution report is not counted
   always_ff @(posedge CLK) begin
      if (RST) begin
         br_count <= '0;
         mp_count <= '0;
      end else if (upd_valid) begin
         if (br_count != 32'hFFFF_FFFF) br_count <= br_count + 32'd1;
         if (mispredict && (mp_count != 32'hFFFF_FFFF)) mp_count <= mp_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (16 entries).
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_predictor;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] fetch_PC;
   logic [31:0] PC4;
   logic        mispredict;
   logic [31:0] correct_PC;
   logic        upd_valid;
   logic [31:0] upd_PC;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [31:0] next_PC;
   logic        pred_taken;
   logic [31:0] br_count;
   logic [31:0] mp_count;

   int checks = 0;
   int errors = 0;

   branch_predictor #(.BTB_ENTRIES(16)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .fetch_PC   (fetch_PC),
      .PC4        (PC4),
      .mispredict (mispredict),
      .correct_PC (correct_PC),
      .upd_valid  (upd_valid),
      .upd_PC     (upd_PC),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .next_PC    (next_PC),
      .pred_taken (pred_taken),
      .br_count   (br_count),
      .mp_count   (mp_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; outputs settle before the next input change
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc);
      fetch_PC = pc;
      PC4      = pc + 32'd4;
      #1;
   endtask

   task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      upd_valid  = 1'b1;
      upd_PC     = pc;
      upd_taken  = taken;
      upd_target = tgt;
      step();
      upd_valid  = 1'b0;
   endtask

   initial begin
      RST = 1'b1; fetch_PC = 32'h100; PC4 = 32'h104;
      mispredict = 1'b1; correct_PC = 32'h400;
      upd_valid = 1'b0; upd_PC = '0; upd_taken = 1'b0; upd_target = '0;
      step();
      // During reset: mispredict ignored, sequential fetch
      check("rst_next_pc_ignores_mp", next_PC, 32'h104);
      check("rst_pred", {31'd0, pred_taken}, 32'd0);
      RST = 1'b0; mispredict = 1'b0;
      fetch(32'h100);

      // 1. post-reset state
      check("s1_pred", {31'd0, pred_taken}, 32'd0);
      check("s1_next_pc", next_PC, 32'h104);
      check("s1_br", br_count, 32'd0);
      check("s1_mp", mp_count, 32'd0);

      // 2. allocate; same-cycle lookup sees old state
      upd_valid = 1'b1; upd_PC = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
      #1;
      check("s2_same_cycle_next", next_PC, 32'h104);
      check("s2_same_cycle_pred", {31'd0, pred_taken}, 32'd0);
      step();
      upd_valid = 1'b0;
      #1;
      check("s2_pred", {31'd0, pred_taken}, 32'd1);
      check("s2_next_pc", next_PC, 32'h200);
      check("s2_br", br_count, 32'd1);

      // 3. hysteresis: 2 -> 3 -> 3, then 2, 1, 0
      train(32'h100, 1'b1, 32'h200);
      train(32'h100, 1'b1, 32'h200);
      check("s3_br", br_count, 32'd3);
      train(32'h100, 1'b0, 32'h0);
      check("s3_nt1_next", next_PC, 32'h200);
      train(32'h100, 1'b0, 32'h0);
      check("s3_nt2_next", next_PC, 32'h104);
      check("s3_nt2_pred", {31'd0, pred_taken}, 32'd0);
      train(32'h100, 1'b0, 32'h0);
      // ctr now 0: one taken reaches only 1, still not predicted
      train(32'h100, 1'b1, 32'h200);
      check("s3_ctr0_then_t", next_PC, 32'h104);
      // second taken reaches 2 and refreshes the target
      train(32'h100, 1'b1, 32'h240);
      check("s3_target_upd", next_PC, 32'h240);
      check("s3_br_total", br_count, 32'd8);
      check("s3_mp", mp_count, 32'd0);

      // 4. aliasing on index 0
      fetch(32'h140);
      check("s4_alias_miss", next_PC, 32'h144);
      check("s4_alias_pred", {31'd0, pred_taken}, 32'd0);
      train(32'h140, 1'b1, 32'h300);
      check("s4_alias_alloc", next_PC, 32'h300);
      fetch(32'h100);
      check("s4_evicted_next", next_PC, 32'h104);
      check("s4_evicted_pred", {31'd0, pred_taken}, 32'd0);

      // 5. redirect with and without a resolution report
      train(32'h100, 1'b1, 32'h200);
      check("s5_retrain", next_PC, 32'h200);
      mispredict = 1'b1; correct_PC = 32'h400;
      upd_valid = 1'b1; upd_PC = 32'h100; upd_taken = 1'b0;
      #1;
      check("s5_redirect", next_PC, 32'h400);
      step();
      upd_valid = 1'b0;
      check("s5_mp", mp_count, 32'd1);
      check("s5_br", br_count, 32'd11);
      correct_PC = 32'h480;
      #1;
      check("s5_redirect_only", next_PC, 32'h480);
      step();
      check("s5_mp_hold", mp_count, 32'd1);
      check("s5_br_hold", br_count, 32'd11);
      mispredict = 1'b0;
      #1;
      // counter dropped to 1 by the not-taken report
      check("s5_ctr_dec", next_PC, 32'h104);

      // 6. reset mid-training drops state and the concurrent update
      train(32'h100, 1'b1, 32'h200);
      check("s6_trained", next_PC, 32'h200);
      RST = 1'b1;
      upd_valid = 1'b1; upd_PC = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
      #1;
      check("s6_rst_pred", {31'd0, pred_taken}, 32'd0);
      check("s6_rst_next", next_PC, 32'h104);
      step();
      RST = 1'b0; upd_valid = 1'b0;
      #1;
      check("s6_lost_pred", {31'd0, pred_taken}, 32'd0);
      check("s6_lost_next", next_PC, 32'h104);
      check("s6_br", br_count, 32'd0);
      check("s6_mp", mp_count, 32'd0);
      fetch(32'h140);
      check("s6_alias_lost", next_PC, 32'h144);
      train(32'h100, 1'b1, 32'h500);
      fetch(32'h100);
      check("s6_retrain", next_PC, 32'h500);
      check("s6_br_after", br_count, 32'd1);
      // held fetch_PC over several cycles has no side effects
      step();
      step();
      check("s6_hold_next", next_PC, 32'h500);
      check("s6_hold_br", br_count, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
